// File: rtl/csc_fifo_arbiter.sv
// Round-robin, burst-locked arbiter sharing one CSC write path among NUM_REQ FIFOs.
// Latency: 1 cycle to grant, then combinational pass-through at 1 word/cycle.
// Backpressure: out_ready passes straight to the granted requester; others see ready=0.
module csc_fifo_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16,
    localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W     = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [SRC_W-1:0]              out_src,
    output logic [CNT_W-1:0]              burst_cnt
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    logic [SRC_W-1:0]      r_grant;
    logic [SRC_W-1:0]      r_rr_ptr;
    logic [CNT_W-1:0]      r_burst_cnt;

    logic [DATA_WIDTH-1:0] w_data [NUM_REQ];
    logic                  w_hit;
    logic [SRC_W-1:0]      w_pick;
    logic [SRC_W-1:0]      w_scan_idx;
    logic                  w_cap;
    logic                  w_xfer;

    // Slice the flat data bus into one word per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin scan: first valid requester after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_hit      = 1'b0;
        w_pick     = '0;
        w_scan_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_scan_idx = SRC_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_hit && req_valid[w_scan_idx]) begin
                w_hit  = 1'b1;
                w_pick = w_scan_idx;
            end
        end
    end

    // Pass-through of the granted requester while locked; everything quiet in IDLE.
    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        w_cap     = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
        if (r_state == ST_LOCKED) begin
            out_valid          = req_valid[r_grant];
            out_data           = w_data[r_grant];
            out_last           = req_last[r_grant] | w_cap;
            req_ready[r_grant] = out_ready;
        end
    end

    assign w_xfer    = out_valid & out_ready;
    assign out_src   = r_grant;
    assign burst_cnt = r_burst_cnt;

    // Grant FSM: lock on a scan hit, count transfers, release on end of column or burst cap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= SRC_W'(NUM_REQ - 1);
            r_grant     <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_grant     <= w_pick;
                        r_burst_cnt <= '0;
                        r_state     <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                        if (out_last) begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= r_grant;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csc_fifo_arbiter.sv
// Bench for csc_fifo_arbiter: fixed vector table, then FIFO-backed requesters checked
// against a transaction-level reference model under directed and random traffic.
module tb_csc_fifo_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 16;

    logic           clock = 1'b0;
    logic           reset;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_last;
    logic [NR-1:0]  req_ready;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic           out_last;
    logic           out_ready;
    logic [1:0]     out_src;
    logic [7:0]     burst_cnt;

    csc_fifo_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .out_src(out_src), .burst_cnt(burst_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b1;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // ---------------- requester FIFOs (bench side) ----------------
    logic [8:0] mem [NR][64];
    int hd [NR];
    int cnt[NR];

    task automatic push(input int i, input logic [8:0] w);
        mem[i][(hd[i] + cnt[i]) % 64] = w;
        cnt[i]++;
    endtask

    task automatic push_col(input int i, input int n, input int base);
        for (int k = 0; k < n; k++) push(i, {(k == n - 1) ? 1'b1 : 1'b0, 8'(base + k)});
    endtask

    // ---------------- reference model ----------------
    bit m_locked;
    int m_g, m_cnt, m_ptr;

    typedef struct { int src; int data; int last; int cnt; int cyc; } xfer_t;
    xfer_t log_q[$];

    task automatic model_reset();
        m_locked = 0; m_g = 0; m_cnt = 0; m_ptr = NR - 1;
    endtask

    // One clock: drive from FIFO heads, compare against model, advance model at the edge.
    task automatic step(input logic rdy, input logic [NR-1:0] hold, input logic rst);
        logic [NR-1:0]    v, l, e_rdy;
        logic [NR*DW-1:0] d;
        logic             e_vld, e_last;
        logic [DW-1:0]    e_dat;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NR; i++) begin
            if (cnt[i] > 0) begin
                v[i] = !hold[i];
                d[i*DW +: DW] = mem[i][hd[i]][7:0];
                l[i] = mem[i][hd[i]][8];
            end
        end
        reset = rst; out_ready = rdy; req_valid = v; req_data = d; req_last = l;
        #1;
        e_rdy = '0; e_vld = 0; e_dat = '0; e_last = 0;
        if (m_locked) begin
            e_vld  = v[m_g];
            e_dat  = d[m_g*DW +: DW];
            e_last = l[m_g] | (m_cnt == MB - 1);
            e_rdy[m_g] = rdy;
        end
        if (cmp_en) begin
            chk("req_ready", int'(req_ready), int'(e_rdy));
            chk("ready_onehot", int'($countones(req_ready) <= 1), 1);
            chk("out_valid", int'(out_valid), int'(e_vld));
            chk("out_data", int'(out_data), int'(e_dat));
            chk("out_last", int'(out_last), int'(e_last));
            chk("out_src", int'(out_src), m_g);
            chk("burst_cnt", int'(burst_cnt), m_cnt);
        end
        @(posedge clock);
        if (rst) begin
            model_reset();
        end else if (!m_locked) begin
            for (int k = 1; k <= NR; k++) begin
                if (!m_locked && v[(m_ptr + k) % NR]) begin
                    m_g = (m_ptr + k) % NR; m_cnt = 0; m_locked = 1;
                end
            end
        end else if (e_vld && rdy) begin
            log_q.push_back('{m_g, int'(e_dat), int'(e_last), m_cnt, cyc});
            hd[m_g] = (hd[m_g] + 1) % 64; cnt[m_g]--;
            m_cnt++;
            if (e_last) begin m_locked = 0; m_ptr = m_g; end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((m_locked || cnt[0] + cnt[1] + cnt[2] + cnt[3] > 0) && n < budget) begin
            step(1'b1, '0, 1'b0);
            n++;
        end
        chk("drain_in_budget", int'(n < budget), 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] v; logic [31:0] d; logic [3:0] l; logic rdy;
        logic [3:0] e_rdy; logic e_vld; logic [7:0] e_dat; logic e_last; logic [1:0] e_src; logic [7:0] e_cnt;
    } vec_t;
    vec_t vt[10];

    initial begin
        int idx, starts[$], last_s;
        // requester 2 column 11,22,33 then requesters 0 and 3 together (rr_ptr=2 -> 3 wins)
        vt[0] = '{4'b0100, 32'h0011_0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 8'd0};
        vt[1] = '{4'b0100, 32'h0011_0000, 4'b0000, 1, 4'b0100, 1, 8'h11, 0, 2'd2, 8'd0};
        vt[2] = '{4'b0100, 32'h0022_0000, 4'b0000, 1, 4'b0100, 1, 8'h22, 0, 2'd2, 8'd1};
        vt[3] = '{4'b0100, 32'h0033_0000, 4'b0100, 1, 4'b0100, 1, 8'h33, 1, 2'd2, 8'd2};
        vt[4] = '{4'b0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 2'd2, 8'd3};
        vt[5] = '{4'b1001, 32'hB300_00A0, 4'b1001, 1, 4'b0000, 0, 8'h00, 0, 2'd2, 8'd3};
        vt[6] = '{4'b1001, 32'hB300_00A0, 4'b1001, 1, 4'b1000, 1, 8'hB3, 1, 2'd3, 8'd0};
        vt[7] = '{4'b0001, 32'h0000_00A0, 4'b0001, 1, 4'b0000, 0, 8'h00, 0, 2'd3, 8'd1};
        vt[8] = '{4'b0001, 32'h0000_00A0, 4'b0001, 1, 4'b0001, 1, 8'hA0, 1, 2'd0, 8'd0};
        vt[9] = '{4'b0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 8'd1};

        for (int i = 0; i < NR; i++) begin hd[i] = 0; cnt[i] = 0; end
        reset = 1; out_ready = 0; req_valid = '0; req_data = '0; req_last = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        model_reset();

        for (int t = 0; t < 10; t++) begin
            req_valid = vt[t].v; req_data = vt[t].d; req_last = vt[t].l; out_ready = vt[t].rdy;
            #1;
            chk($sformatf("vec%0d_ready", t), int'(req_ready), int'(vt[t].e_rdy));
            chk($sformatf("vec%0d_valid", t), int'(out_valid), int'(vt[t].e_vld));
            chk($sformatf("vec%0d_data", t), int'(out_data), int'(vt[t].e_dat));
            chk($sformatf("vec%0d_last", t), int'(out_last), int'(vt[t].e_last));
            chk($sformatf("vec%0d_src", t), int'(out_src), int'(vt[t].e_src));
            chk($sformatf("vec%0d_cnt", t), int'(burst_cnt), int'(vt[t].e_cnt));
            @(posedge clock); cyc++;
            @(negedge clock);
        end

        // resync the model through a reset cycle
        cmp_en = 0; step(1'b0, '0, 1'b1); cmp_en = 1;

        // fairness: four requesters with two 2-word columns each
        for (int r = 0; r < 2; r++) for (int i = 0; i < NR; i++) push_col(i, 2, 16 * i + 4 * r);
        log_q.delete();
        drain(100);
        starts.delete();
        foreach (log_q[k]) if (log_q[k].cnt == 0) starts.push_back(k);
        chk("fair_bursts", starts.size(), 8);
        for (int k = 0; k < starts.size() && k < 8; k++) begin
            chk($sformatf("fair_order%0d", k), log_q[starts[k]].src, k % NR);
            if (k > 0) chk($sformatf("fair_gap%0d", k), log_q[starts[k]].cyc - log_q[starts[k-1]].cyc, 3);
        end

        // burst cap: requester 1 streams 20 words, others join after the grant
        step(1'b0, '0, 1'b1);
        push_col(1, 20, 1);
        log_q.delete();
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        push_col(2, 2, 8'h20); push_col(3, 2, 8'h30); push_col(0, 2, 8'h50);
        drain(200);
        idx = -1;
        foreach (log_q[k]) if (idx < 0 && log_q[k].last == 1) idx = k;
        chk("cap_found", int'(idx >= 0), 1);
        if (idx >= 0) begin
            chk("cap_src", log_q[idx].src, 1);
            chk("cap_word", log_q[idx].data, 16);
            chk("cap_cnt", log_q[idx].cnt, 15);
            starts.delete();
            for (int k = idx + 1; k < log_q.size(); k++) if (log_q[k].cnt == 0) starts.push_back(k);
            chk("cap_after_bursts", starts.size(), 4);
            if (starts.size() >= 4) begin
                chk("cap_next0", log_q[starts[0]].src, 2);
                chk("cap_next1", log_q[starts[1]].src, 3);
                chk("cap_next2", log_q[starts[2]].src, 0);
                chk("cap_resume_src", log_q[starts[3]].src, 1);
                chk("cap_resume_word", log_q[starts[3]].data, 17);
            end
        end

        // downstream stall: ready pattern 1,0,0,1 on requester 0
        step(1'b0, '0, 1'b1);
        push_col(0, 4, 8'h60); push_col(1, 1, 8'h70);
        log_q.delete();
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        #1;
        chk("stall_xfers", log_q.size(), 2);
        chk("stall_cnt", int'(burst_cnt), 2);
        drain(50);

        // reset mid-burst from requester 3, then 0 and 3 compete
        step(1'b0, '0, 1'b1);
        push_col(3, 5, 8'h80);
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_src", int'(out_src), 0);
        chk("rst_cnt", int'(burst_cnt), 0);
        push_col(0, 1, 8'h90);
        log_q.delete();
        drain(50);
        chk("rst_first_src", (log_q.size() > 0) ? log_q[0].src : -1, 0);

        // requester 1 drops valid for two cycles mid-column; requester 2 waiting
        step(1'b0, '0, 1'b1);
        push_col(1, 4, 8'h41); push_col(2, 2, 8'h20);
        log_q.delete();
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        chk("drop_held_xfers", log_q.size(), 2);
        drain(50);
        chk("drop_src2", (log_q.size() > 3) ? log_q[2].src : -1, 1);
        chk("drop_src3", (log_q.size() > 3) ? log_q[3].src : -1, 1);
        chk("drop_word3", (log_q.size() > 3) ? log_q[3].data : -1, 8'h44);

        // random traffic against the model
        step(1'b0, '0, 1'b1);
        for (int n = 0; n < 1500; n++) begin
            int i;
            i = $urandom_range(0, NR - 1);
            if ($urandom % 6 == 0 && cnt[i] < 40) push_col(i, $urandom_range(1, 20), $urandom_range(0, 255));
            step(($urandom % 4) != 0, ($urandom % 4 == 0) ? 4'($urandom) : 4'b0000, 1'b0);
        end
        drain(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csc_fifo_arbiter.md
# csc_fifo_arbiter

Round-robin, burst-locked arbiter that shares one downstream CSC write path (GLB write port) among NUM_REQ CSC switch FIFO outputs. Each requester presents a valid/ready stream of encoded CSC words terminated by a `last` flag (end of column). Once granted, a requester keeps the path until its column ends or MAX_BURST words have passed. The block sits between the per-channel CSC encoder FIFOs and the GLB write interface.

## Interface
- DATA_WIDTH, 8, width of one CSC word (value or count/address word)
- NUM_REQ, 4, number of requesting FIFOs; legal range 2–8
- MAX_BURST, 16, maximum words per grant before forced release; legal range 2–255
- SRC_W (derived, not overridable) = ceil(log2(NUM_REQ)); CNT_W = 8

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester valid; bit i = requester i
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  per-requester end-of-column flag, qualified by req_valid
- req_ready  out  NUM_REQ  per-requester ready; at most one bit set
- out_valid  out  1  downstream valid
- out_data  out  DATA_WIDTH  downstream word
- out_last  out  1  downstream end-of-burst flag
- out_ready  in  1  downstream ready
- out_src  out  SRC_W  index of the granted requester
- burst_cnt  out  CNT_W  words already accepted in the current grant

## Operation
- State machine: IDLE, LOCKED.
- IDLE: req_ready = 0, out_valid = 0, out_data = 0, out_last = 0. The arbiter scans requesters starting at (rr_ptr+1) mod NUM_REQ and picks the first one with req_valid = 1. On a hit, it registers grant <= index, clears burst_cnt to 0 and moves to LOCKED. With no valid requester it stays in IDLE.
- LOCKED: pure combinational pass-through of the granted requester g.
  - out_valid = req_valid[g]
  - out_data = req_data[g]
  - req_ready[g] = out_ready; all other ready bits are 0
  - out_last = req_last[g] | (burst_cnt == MAX_BURST-1)
- Transfer = out_valid & out_ready. Each transfer increments burst_cnt by 1.
- Release: a transfer with out_last = 1 returns the FSM to IDLE and sets rr_ptr <= g. The release cause can be req_last or the cap.
- A cap release does not consume or alter the requester's req_last. The requester's remaining words re-arbitrate as a new burst.
- req_valid[g] may drop while LOCKED. The grant is held; output is idle-valid until valid returns or reset.
- out_src = g while LOCKED; it holds the last granted value in IDLE.
- Non-granted requesters are never acknowledged, so their FIFOs hold data unchanged.

## Timing
- Reset values: state IDLE, rr_ptr = NUM_REQ-1 (requester 0 has first priority), grant/out_src = 0, burst_cnt = 0, all req_ready = 0, out_valid = 0, out_data = 0, out_last = 0.
- Arbitration latency: 1 cycle. Request visible in cycle t gives LOCKED in t+1, and the first word can transfer in t+1.
- Throughput in LOCKED: 1 word/cycle with out_ready held at 1.
- Burst overhead: 1 idle cycle between consecutive bursts (the IDLE cycle after release). Bursts of B words occupy B+1 cycles when back-to-back.
- Fairness: with all requesters continuously valid, grant order is 0,1,…,NUM_REQ-1,0,… and no requester waits more than NUM_REQ-1 bursts.
- Wrap-around: the scan index and rr_ptr wrap modulo NUM_REQ. For non-power-of-2 NUM_REQ, indices ≥ NUM_REQ are never produced.
- Simultaneous events:
  - req_last and the cap in the same transfer cause a single release.
  - New requests arriving during LOCKED are only considered in the next IDLE cycle.
- Downstream stall (out_ready = 0): no state change; out_data/out_last remain a function of the granted requester's inputs.
- Reset mid-burst: the next cycle is IDLE with the reset values above. burst_cnt is lost, and the interrupted column is not resumed.

## Test plan
- Reset, then only requester 2 valid with a 3-word column (0x11, 0x22, 0x33 with last on 0x33), out_ready = 1 → out_src = 2 in the cycle after the request, then 3 consecutive transfers with out_last only on 0x33, then IDLE for 1 cycle.
- All 4 requesters valid with 2-word columns → grants 0,1,2,3,0 in order; each burst takes 3 cycles; req_ready never has more than one bit set.
- Requester 1 streams 20 words with no last, MAX_BURST = 16 → out_last forced on word 16 and burst_cnt = 15 at that transfer. Requesters 2, 3, 0 are then served if valid; requester 1 resumes with word 17.
- Granted requester 0 with out_ready toggling 1,0,0,1 → words transfer only on ready cycles, burst_cnt increments only on transfers, and other FIFOs see req_ready = 0.
- Reset asserted for 1 cycle in the middle of a 5-word burst from requester 3 → all outputs at reset values the next cycle. After reset, with requesters 0 and 3 valid, requester 0 is granted first.
- Requester 1 drops req_valid for 2 cycles mid-column → grant held, out_valid = 0 for those 2 cycles, and no other requester is served until requester 1's last word.
